// File: rtl/dmem_store_buffer_if.sv
// Memory-side write channel of the store buffer: valid/ready handshake
// carrying one address/data pair per accepted transfer.
interface dmem_store_buffer_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;

    // The buffer drives the write; data memory only answers with ready.
    modport master (
        output mem_valid,
        output mem_addr,
        output mem_wdata,
        input  mem_ready
    );

    modport slave (
        input  mem_valid,
        input  mem_addr,
        input  mem_wdata,
        output mem_ready
    );
endinterface

// File: rtl/dmem_store_buffer.sv
// Posted-write store buffer: in-order ring of pending stores drained to data
// memory, with full-stall towards the core and youngest-match load forwarding.
module dmem_store_buffer #(
    parameter int DEPTH = 4,
    parameter int AW    = 32,
    parameter int DW    = 32
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         memwrite,
    input  logic [AW-1:0]                dataadr,
    input  logic [DW-1:0]                writedata,
    output logic                         stall,
    input  logic                         ld_en,
    input  logic [AW-1:0]                ld_addr,
    output logic                         ld_hit,
    output logic [DW-1:0]                ld_data,
    dmem_store_buffer_if.master          mem,
    output logic                         empty,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];

    logic          enq;
    logic          deq;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;
    logic [PW-1:0] fwd_idx;

    // Full is judged on the registered count only, so a same-cycle drain
    // never lets a new store slip in.
    assign enq   = memwrite & (count_q != FULL_CNT);
    assign stall = memwrite & (count_q == FULL_CNT);
    assign deq   = (count_q != '0) & mem.mem_ready;

    assign mem.mem_valid = (count_q != '0);
    assign mem.mem_addr  = addr_q[head_q];
    assign mem.mem_wdata = data_q[head_q];
    assign empty         = (count_q == '0);
    assign count         = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (deq) begin
            head_d = head_q + PW'(1);
        end
        if (enq) begin
            tail_d = tail_q + PW'(1);
        end
        if (enq && !deq) begin
            count_d = count_q + CW'(1);
        end else if (deq && !enq) begin
            count_d = count_q - CW'(1);
        end
    end

    always_comb begin
        addr_d = addr_q;
        data_d = data_q;
        if (enq) begin
            addr_d[tail_q] = dataadr;
            data_d[tail_q] = writedata;
        end
    end

    // Walk from oldest to youngest so the last match seen is the youngest;
    // the head being drained this cycle is still part of the live window.
    always_comb begin
        fwd_hit  = 1'b0;
        fwd_data = '0;
        fwd_idx  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = head_q + PW'(k);
            if ((CW'(k) < count_q) && (addr_q[fwd_idx] == ld_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_q[fwd_idx];
            end
        end
    end

    assign ld_hit  = ld_en & fwd_hit;
    assign ld_data = ld_hit ? fwd_data : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entries are cleared too so the head outputs are never X when idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
        end else begin
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

endmodule
